// File: rtl/d_input_debouncer_if.sv
// Signal bundle between a raw input source and the debouncer.
// The source (master) drives the raw level; the debouncer (slave) returns the clean level, edge pulses and busy.
interface d_input_debouncer_if;
    logic d;
    logic q;
    logic rise;
    logic fall;
    logic busy;

    modport master (
        output d,
        input  q,
        input  rise,
        input  fall,
        input  busy
    );

    modport slave (
        input  d,
        output q,
        output rise,
        output fall,
        output busy
    );
endinterface

// File: rtl/d_input_debouncer.sv
// Debounces a raw asynchronous 1-bit input into a registered level plus one-cycle rise/fall pulses.
// A change is accepted only after the synchronized input has differed from q on STABLE_CYCLES consecutive edges.
module d_input_debouncer #(
    parameter int unsigned STABLE_CYCLES = 8,
    parameter int unsigned CNT_WIDTH     = 4
) (
    input logic                 clk_i,
    input logic                 rst_i,
    d_input_debouncer_if.slave  bus_if
);
    localparam logic [0:0]           StStable = 1'b0;
    localparam logic [0:0]           StWait   = 1'b1;
    localparam logic [CNT_WIDTH-1:0] CntLast  = CNT_WIDTH'(STABLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CntOne   = CNT_WIDTH'(1);

    logic                 sync1_q;
    logic                 sync2_q;
    logic [0:0]           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 level_q, level_d;
    logic                 rise_q, rise_d;
    logic                 fall_q, fall_d;
    logic                 diff;

    always_comb begin
        diff    = (sync2_q != level_q);
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (state_q == StStable) begin
            if (diff) begin
                state_d = StWait;
                cnt_d   = CntOne;
            end else begin
                cnt_d   = '0;
            end
        end else begin
            // A bounce back to the current level abandons the candidate silently.
            if (!diff) begin
                state_d = StStable;
                cnt_d   = '0;
            end else if (cnt_q == CntLast) begin
                level_d = ~level_q;
                rise_d  = ~level_q;
                fall_d  = level_q;
                state_d = StStable;
                cnt_d   = '0;
            end else begin
                cnt_d   = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= StStable;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= bus_if.d;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // busy comes straight from the state flop, so it has no combinational path from d.
    assign bus_if.q    = level_q;
    assign bus_if.rise = rise_q;
    assign bus_if.fall = fall_q;
    assign bus_if.busy = (state_q == StWait);
endmodule

// File: tb/tb_d_input_debouncer.sv
// Self-checking bench for d_input_debouncer: directed scenarios plus random bouncy input,
// all compared against a run-length reference model of the debounce rule.
module tb_d_input_debouncer;
    localparam int STABLE = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    d_input_debouncer_if bus ();

    d_input_debouncer #(
        .STABLE_CYCLES (STABLE),
        .CNT_WIDTH     (4)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus_if (bus)
    );

    always #5 clk = ~clk;

    // Reference model: d reaches the decision point two edges late; q flips after STABLE
    // consecutive edges on which that delayed value disagrees with q.
    logic mHist[$];
    logic mq;
    int   run;
    logic eRise, eFall, eBusy;

    task automatic tick(input logic dVal, input logic rVal);
        logic s2;
        @(negedge clk);
        bus.d = dVal;
        rst   = rVal;
        @(posedge clk);
        eRise = 1'b0;
        eFall = 1'b0;
        if (rVal) begin
            mHist = '{1'b0, 1'b0};
            mq    = 1'b0;
            run   = 0;
        end else begin
            s2 = mHist.pop_front();
            mHist.push_back(dVal);
            if (s2 != mq) begin
                run++;
                if (run == STABLE) begin
                    mq    = ~mq;
                    eRise = mq;
                    eFall = ~mq;
                    run   = 0;
                end
            end else begin
                run = 0;
            end
        end
        eBusy = (run != 0);
        #1;
    endtask

    task automatic test_reset();
        int nonZero = 0;
        int busySeen = 0;
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        checks++;
        if ({bus.q, bus.rise, bus.fall, bus.busy} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_values: got q/rise/fall/busy=%b expected 0000",
                     {bus.q, bus.rise, bus.fall, bus.busy});
        end
        for (int i = 1; i <= 20; i++) begin
            tick(1'b0, 1'b0);
            checks++;
            if ({bus.q, bus.rise, bus.fall, bus.busy} !== {mq, eRise, eFall, eBusy}) begin
                errors++;
                $display("[TB] FAIL reset_idle_model edge %0d: got %b expected %b", i,
                         {bus.q, bus.rise, bus.fall, bus.busy}, {mq, eRise, eFall, eBusy});
            end
            if ({bus.q, bus.rise, bus.fall, bus.busy} !== 4'b0000) nonZero++;
            if (bus.busy) busySeen++;
        end
        checks++;
        if (nonZero != 0) begin
            errors++;
            $display("[TB] FAIL reset_idle_outputs: got %0d nonzero cycles expected 0", nonZero);
        end
        checks++;
        if (busySeen != 0) begin
            errors++;
            $display("[TB] FAIL reset_idle_busy: got %0d busy cycles expected 0", busySeen);
        end
    endtask

    task automatic test_clean_step();
        int busyEdge = -1;
        int qEdge = -1;
        int riseEdge = -1;
        int rises = 0;
        for (int i = 1; i <= 20; i++) begin
            tick(1'b1, 1'b0);
            checks++;
            if ({bus.q, bus.rise, bus.fall, bus.busy} !== {mq, eRise, eFall, eBusy}) begin
                errors++;
                $display("[TB] FAIL clean_step_model edge %0d: got %b expected %b", i,
                         {bus.q, bus.rise, bus.fall, bus.busy}, {mq, eRise, eFall, eBusy});
            end
            if (bus.busy && busyEdge < 0) busyEdge = i;
            if (bus.q && qEdge < 0) qEdge = i;
            if (bus.rise) begin
                rises++;
                if (riseEdge < 0) riseEdge = i;
            end
        end
        checks++;
        if (busyEdge != 3) begin
            errors++;
            $display("[TB] FAIL clean_step_busy_edge: got %0d expected 3", busyEdge);
        end
        checks++;
        if (qEdge != STABLE + 2) begin
            errors++;
            $display("[TB] FAIL clean_step_q_edge: got %0d expected %0d", qEdge, STABLE + 2);
        end
        checks++;
        if (rises != 1 || riseEdge != STABLE + 2) begin
            errors++;
            $display("[TB] FAIL clean_step_rise: got %0d pulses at edge %0d expected 1 at edge %0d",
                     rises, riseEdge, STABLE + 2);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clean_step_busy_end: got %b expected 0", bus.busy);
        end
    endtask

    task automatic test_bounce();
        logic pat [5];
        int   bounceRises = 0;
        int   busyToggles = 0;
        int   rises = 0;
        int   riseEdge = -1;
        logic prevBusy;
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 12; i++) tick(1'b0, 1'b0);
        checks++;
        if (bus.q !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bounce_setup_q: got %b expected 0", bus.q);
        end
        prevBusy = bus.busy;
        for (int i = 0; i < 5; i++) begin
            tick(pat[i], 1'b0);
            checks++;
            if ({bus.q, bus.rise, bus.fall, bus.busy} !== {mq, eRise, eFall, eBusy}) begin
                errors++;
                $display("[TB] FAIL bounce_model step %0d: got %b expected %b", i,
                         {bus.q, bus.rise, bus.fall, bus.busy}, {mq, eRise, eFall, eBusy});
            end
            if (bus.rise) bounceRises++;
            if (bus.busy != prevBusy) busyToggles++;
            prevBusy = bus.busy;
        end
        for (int i = 1; i <= 20; i++) begin
            tick(1'b1, 1'b0);
            checks++;
            if ({bus.q, bus.rise, bus.fall, bus.busy} !== {mq, eRise, eFall, eBusy}) begin
                errors++;
                $display("[TB] FAIL bounce_hold_model edge %0d: got %b expected %b", i,
                         {bus.q, bus.rise, bus.fall, bus.busy}, {mq, eRise, eFall, eBusy});
            end
            if (bus.busy != prevBusy) busyToggles++;
            prevBusy = bus.busy;
            if (bus.rise) begin
                rises++;
                if (riseEdge < 0) riseEdge = i;
            end
        end
        checks++;
        if (bounceRises != 0) begin
            errors++;
            $display("[TB] FAIL bounce_no_rise: got %0d rises expected 0", bounceRises);
        end
        checks++;
        if (busyToggles < 2) begin
            errors++;
            $display("[TB] FAIL bounce_busy_toggle: got %0d toggles expected at least 2", busyToggles);
        end
        checks++;
        if (rises != 1 || riseEdge != STABLE + 2) begin
            errors++;
            $display("[TB] FAIL bounce_rise: got %0d pulses at edge %0d expected 1 at edge %0d",
                     rises, riseEdge, STABLE + 2);
        end
    endtask

    task automatic test_glitch();
        for (int lowLen = STABLE - 1; lowLen <= STABLE; lowLen++) begin
            int falls = 0;
            int fallEdge = -1;
            int qDropped = 0;
            checks++;
            if (bus.q !== 1'b1) begin
                errors++;
                $display("[TB] FAIL glitch_setup_q len %0d: got %b expected 1", lowLen, bus.q);
            end
            for (int i = 1; i <= lowLen + 12; i++) begin
                tick((i <= lowLen) ? 1'b0 : 1'b1, 1'b0);
                checks++;
                if ({bus.q, bus.rise, bus.fall, bus.busy} !== {mq, eRise, eFall, eBusy}) begin
                    errors++;
                    $display("[TB] FAIL glitch_model len %0d edge %0d: got %b expected %b", lowLen, i,
                             {bus.q, bus.rise, bus.fall, bus.busy}, {mq, eRise, eFall, eBusy});
                end
                if (!bus.q) qDropped++;
                if (bus.fall) begin
                    falls++;
                    if (fallEdge < 0) fallEdge = i;
                end
            end
            checks++;
            if (lowLen < STABLE) begin
                if (falls != 0 || qDropped != 0) begin
                    errors++;
                    $display("[TB] FAIL glitch_reject: got %0d falls, %0d low cycles expected 0 and 0",
                             falls, qDropped);
                end
            end else begin
                if (falls != 1 || fallEdge != STABLE + 2) begin
                    errors++;
                    $display("[TB] FAIL glitch_accept: got %0d falls at edge %0d expected 1 at edge %0d",
                             falls, fallEdge, STABLE + 2);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int preRises = 0;
        int rises = 0;
        int riseEdge = -1;
        for (int i = 0; i < 12; i++) tick(1'b0, 1'b0);
        for (int i = 1; i <= 7; i++) begin
            tick(1'b1, 1'b0);
            if (bus.rise) preRises++;
        end
        checks++;
        if (bus.busy !== 1'b1 || bus.q !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid_pending: got busy=%b q=%b expected busy=1 q=0", bus.busy, bus.q);
        end
        tick(1'b1, 1'b1);
        if (bus.rise) preRises++;
        checks++;
        if ({bus.q, bus.rise, bus.fall, bus.busy} !== 4'b0000 || preRises != 0) begin
            errors++;
            $display("[TB] FAIL reset_mid_discard: got %b with %0d rises expected 0000 with 0",
                     {bus.q, bus.rise, bus.fall, bus.busy}, preRises);
        end
        for (int i = 1; i <= 15; i++) begin
            tick(1'b1, 1'b0);
            checks++;
            if ({bus.q, bus.rise, bus.fall, bus.busy} !== {mq, eRise, eFall, eBusy}) begin
                errors++;
                $display("[TB] FAIL reset_mid_model edge %0d: got %b expected %b", i,
                         {bus.q, bus.rise, bus.fall, bus.busy}, {mq, eRise, eFall, eBusy});
            end
            if (bus.rise) begin
                rises++;
                if (riseEdge < 0) riseEdge = i;
            end
        end
        checks++;
        if (rises != 1 || riseEdge != STABLE + 2) begin
            errors++;
            $display("[TB] FAIL reset_mid_rise: got %0d pulses at edge %0d expected 1 at edge %0d",
                     rises, riseEdge, STABLE + 2);
        end
    endtask

    task automatic test_back_to_back();
        int rises = 0;
        int falls = 0;
        int riseEdge = -1;
        int fallEdge = -1;
        int both = 0;
        for (int i = 0; i < 12; i++) tick(1'b0, 1'b0);
        for (int i = 1; i <= 36; i++) begin
            tick((i <= 12) ? 1'b1 : 1'b0, 1'b0);
            checks++;
            if ({bus.q, bus.rise, bus.fall, bus.busy} !== {mq, eRise, eFall, eBusy}) begin
                errors++;
                $display("[TB] FAIL back_to_back_model edge %0d: got %b expected %b", i,
                         {bus.q, bus.rise, bus.fall, bus.busy}, {mq, eRise, eFall, eBusy});
            end
            if (bus.rise && bus.fall) both++;
            if (bus.rise) begin
                rises++;
                riseEdge = i;
            end
            if (bus.fall) begin
                falls++;
                fallEdge = i;
            end
        end
        checks++;
        if (rises != 1 || falls != 1) begin
            errors++;
            $display("[TB] FAIL back_to_back_counts: got rises=%0d falls=%0d expected 1 and 1", rises, falls);
        end
        checks++;
        if (fallEdge - riseEdge != 12) begin
            errors++;
            $display("[TB] FAIL back_to_back_spacing: got %0d expected 12", fallEdge - riseEdge);
        end
        checks++;
        if (both != 0) begin
            errors++;
            $display("[TB] FAIL back_to_back_exclusive: got %0d overlap cycles expected 0", both);
        end
    endtask

    task automatic test_random();
        int   step = 0;
        int   both = 0;
        logic dVal;
        logic rVal;
        int   holdLen;
        while (step < 1500) begin
            dVal    = 1'($urandom_range(0, 1));
            holdLen = ($urandom_range(0, 3) == 0) ? int'($urandom_range(STABLE - 1, STABLE + 4))
                                                  : int'($urandom_range(1, STABLE));
            for (int i = 0; i < holdLen; i++) begin
                rVal = ($urandom_range(0, 199) == 0);
                tick(dVal, rVal);
                step++;
                checks++;
                if ({bus.q, bus.rise, bus.fall, bus.busy} !== {mq, eRise, eFall, eBusy}) begin
                    errors++;
                    $display("[TB] FAIL random_model step %0d: got %b expected %b", step,
                             {bus.q, bus.rise, bus.fall, bus.busy}, {mq, eRise, eFall, eBusy});
                end
                if (bus.rise && bus.fall) both++;
            end
        end
        checks++;
        if (both != 0) begin
            errors++;
            $display("[TB] FAIL random_exclusive: got %0d overlap cycles expected 0", both);
        end
    endtask

    initial begin
        bus.d = 1'b0;
        mHist = '{1'b0, 1'b0};
        mq    = 1'b0;
        run   = 0;
        eRise = 1'b0;
        eFall = 1'b0;
        eBusy = 1'b0;
        test_reset();
        test_clean_step();
        test_bounce();
        test_glitch();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
